// File: rtl/add_serial_pkg.sv
// add_serial_pkg: shared types and helpers for the parametrised serial
// adder/subtractor.
//   state_t  - FSM encoding (IDLE, DELAY, ADD, DONE), 2 bits
//   steps()  - number of ADD cycles for a WIDTH/DIGIT pair
//   cfg_ok() - parameter legality, checked at elaboration by the top
package add_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int steps(input int width, input int digit);
        return width / digit;
    endfunction

    // DIGIT must tile WIDTH exactly and the delay counter is only 4 bits.
    function automatic bit cfg_ok(input int width, input int digit, input int pre_delay);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0) &&
               (pre_delay >= 0) && (pre_delay <= 15);
    endfunction

endpackage

// File: rtl/add_serial_digit.sv
// add_serial_digit: combinational DIGIT-bit adder slice.
//   a, b  in  DIGIT  operand digits
//   cin   in  1      carry in
//   sum   out DIGIT  digit sum
//   cout  out 1      carry out of the digit
module add_serial_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] s;

    assign s    = {1'b0, a} + {1'b0, b} + (DIGIT+1)'(cin);
    assign sum  = s[DIGIT-1:0];
    assign cout = s[DIGIT];

endmodule

// File: rtl/add_serial_param.sv
// add_serial_param: multi-cycle serial adder/subtractor, DIGIT bits per cycle.
//   clk, rst      clock (rising edge), async active-high reset
//   en            start strobe in IDLE, acknowledge strobe in DONE
//   sub           0 = a+b, 1 = a-b (sampled at load)
//   a, b          WIDTH-bit operands (XOR-masked at load)
//   ready/busy/done  state indications (IDLE / DELAY or ADD / DONE)
//   out           result, filled LSB digit first from the top
//   cout          final carry (subtract: 1 = no borrow)
//   ovf           two's-complement overflow of the result
module add_serial_param
    import add_serial_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DIGIT     = 1,
    parameter logic [WIDTH-1:0] A_MASK    = '0,
    parameter logic [WIDTH-1:0] B_MASK    = '0,
    parameter int               PRE_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = steps(WIDTH, DIGIT);
    localparam int CW    = $clog2(STEPS) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);
    localparam logic [3:0]    DLY_LAST  = (PRE_DELAY > 0) ? 4'(PRE_DELAY - 1) : 4'd0;

    generate
        if (!cfg_ok(WIDTH, DIGIT, PRE_DELAY)) begin : g_bad_cfg
            $error("add_serial_param: illegal WIDTH/DIGIT/PRE_DELAY combination");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_reg, b_reg, out_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic [3:0]       dcnt;
    logic             sa, sb;
    logic             cout_r, ovf_r;

    logic [WIDTH-1:0] a_ld, b_eff;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic [WIDTH-1:0] out_next;

    assign a_ld  = a ^ A_MASK;
    // Subtract is a + ~b + 1: invert here, the +1 comes from carry <= sub.
    assign b_eff = (b ^ B_MASK) ^ {WIDTH{sub}};

    add_serial_digit #(.DIGIT(DIGIT)) u_digit (
        .a   (a_reg[DIGIT-1:0]),
        .b   (b_reg[DIGIT-1:0]),
        .cin (carry),
        .sum (d_sum),
        .cout(d_cout)
    );

    // New digit enters at the top; after STEPS shifts the first digit sits at the LSB.
    generate
        if (DIGIT == WIDTH) begin : g_full
            assign out_next = d_sum;
        end else begin : g_shift
            assign out_next = {d_sum, out_r[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            out_r  <= '0;
            carry  <= 1'b0;
            count  <= '0;
            dcnt   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        a_reg  <= a_ld;
                        b_reg  <= b_eff;
                        carry  <= sub;
                        count  <= '0;
                        dcnt   <= '0;
                        out_r  <= '0;
                        cout_r <= 1'b0;
                        ovf_r  <= 1'b0;
                        sa     <= a_ld[WIDTH-1];
                        sb     <= b_eff[WIDTH-1];
                        state  <= (PRE_DELAY > 0) ? DELAY : ADD;
                    end
                end
                DELAY: begin
                    if (dcnt == DLY_LAST) begin
                        state <= ADD;
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                ADD: begin
                    out_r <= out_next;
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= d_cout;
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        cout_r <= d_cout;
                        // Same-sign operands producing an opposite-sign result.
                        ovf_r  <= (sa == sb) && (d_sum[DIGIT-1] != sa);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (en) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == DELAY) || (state == ADD);
    assign done  = (state == DONE);
    assign out   = out_r;
    assign cout  = cout_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_add_serial_param.sv
// tb_add_serial_param: directed bench over five configurations of add_serial_param.
//   0: W8  D1 PD1 masks 0        1: W8 D4 PD0 masks 0
//   2: W8  D1 PD1 A=5A B=00      3: W8 D1 PD1 A=5A B=FF
//   4: W16 D8 PD15 masks 0
// Latency is counted in rising edges starting with the edge that samples en.
module tb_add_serial_param;

    logic clk, rst, sub;
    logic [4:0] en;
    logic [15:0] a16, b16;
    logic [4:0] rdy, bsy, dn, co, ov;
    logic [4:0][15:0] res;
    int total, passed;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign res[0][15:8] = '0;
    assign res[1][15:8] = '0;
    assign res[2][15:8] = '0;
    assign res[3][15:8] = '0;

    add_serial_param #(.WIDTH(8), .DIGIT(1), .A_MASK(8'h00), .B_MASK(8'h00), .PRE_DELAY(1)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .sub(sub), .a(a16[7:0]), .b(b16[7:0]),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .out(res[0][7:0]), .cout(co[0]), .ovf(ov[0]));
    add_serial_param #(.WIDTH(8), .DIGIT(4), .A_MASK(8'h00), .B_MASK(8'h00), .PRE_DELAY(0)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .sub(sub), .a(a16[7:0]), .b(b16[7:0]),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .out(res[1][7:0]), .cout(co[1]), .ovf(ov[1]));
    add_serial_param #(.WIDTH(8), .DIGIT(1), .A_MASK(8'h5A), .B_MASK(8'h00), .PRE_DELAY(1)) u2 (
        .clk(clk), .rst(rst), .en(en[2]), .sub(sub), .a(a16[7:0]), .b(b16[7:0]),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .out(res[2][7:0]), .cout(co[2]), .ovf(ov[2]));
    add_serial_param #(.WIDTH(8), .DIGIT(1), .A_MASK(8'h5A), .B_MASK(8'hFF), .PRE_DELAY(1)) u3 (
        .clk(clk), .rst(rst), .en(en[3]), .sub(sub), .a(a16[7:0]), .b(b16[7:0]),
        .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .out(res[3][7:0]), .cout(co[3]), .ovf(ov[3]));
    add_serial_param #(.WIDTH(16), .DIGIT(8), .A_MASK(16'h0000), .B_MASK(16'h0000), .PRE_DELAY(15)) u4 (
        .clk(clk), .rst(rst), .en(en[4]), .sub(sub), .a(a16), .b(b16),
        .ready(rdy[4]), .busy(bsy[4]), .done(dn[4]), .out(res[4]), .cout(co[4]), .ovf(ov[4]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at #1 after a rising edge with the target unit idle.
    task automatic run(input int idx, input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic s_i, input int exp_edges, input bit toggle);
        int n;
        a16 = a_i; b16 = b_i; sub = s_i;
        en[idx] = 1'b1;
        @(posedge clk); #1;
        en[idx] = 1'b0;
        n = 1;
        while (!dn[idx] && n < 100) begin
            if (toggle) en[idx] = ~en[idx];
            @(posedge clk); #1;
            n++;
        end
        en[idx] = 1'b0;
        chk($sformatf("done[%0d]", idx), 32'(dn[idx]), 32'd1);
        chk($sformatf("latency[%0d]", idx), 32'(n), 32'(exp_edges));
    endtask

    task automatic ack(input int idx);
        en[idx] = 1'b1;
        @(posedge clk); #1;
        en[idx] = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0;
        rst = 1'b1; en = '0; sub = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_busy",  32'(bsy[0]), 32'd0);
        chk("rst_done",  32'(dn[0]),  32'd0);
        chk("rst_out",   32'(res[0]), 32'h0);
        chk("rst_flags", 32'({co[0], ov[0]}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 0x5A + 0x3C = 0x96: positive + positive -> negative
        run(0, 16'h005A, 16'h003C, 1'b0, 10, 1'b0);
        chk("add_out",  32'(res[0]), 32'h96);
        chk("add_cout", 32'(co[0]),  32'd0);
        chk("add_ovf",  32'(ov[0]),  32'd1);
        ack(0);

        // 0x10 - 0x20 = 0xF0 with borrow
        run(0, 16'h0010, 16'h0020, 1'b1, 10, 1'b0);
        chk("sub_out",  32'(res[0]), 32'hF0);
        chk("sub_cout", 32'(co[0]),  32'd0);
        chk("sub_ovf",  32'(ov[0]),  32'd0);
        chk("sub_hold_busy", 32'(bsy[0]), 32'd0);
        ack(0);
        chk("ack_ready", 32'(rdy[0]), 32'd1);
        chk("ack_done",  32'(dn[0]),  32'd0);
        chk("ack_out",   32'(res[0]), 32'hF0);
        @(posedge clk); #1;
        chk("idle_hold", 32'(rdy[0]), 32'd1);

        // DIGIT=4, no delay: 0xFF + 0x01 wraps to 0 with carry
        run(1, 16'h00FF, 16'h0001, 1'b0, 3, 1'b0);
        chk("d4_out",  32'(res[1]), 32'h00);
        chk("d4_cout", 32'(co[1]),  32'd1);
        chk("d4_ovf",  32'(ov[1]),  32'd0);

        // Masked operands: (0x00^0x5A) + 0x3C and (0x00^0x5A) + (0xC3^0xFF)
        run(2, 16'h0000, 16'h003C, 1'b0, 10, 1'b0);
        chk("amask_out", 32'(res[2]), 32'h96);
        run(3, 16'h0000, 16'h00C3, 1'b0, 10, 1'b0);
        chk("bmask_out", 32'(res[3]), 32'h96);
        chk("bmask_ovf", 32'(ov[3]),  32'd1);

        // en toggling while busy must not restart the operation
        run(0, 16'h005A, 16'h003C, 1'b0, 10, 1'b1);
        chk("tog_out", 32'(res[0]), 32'h96);
        ack(0);

        // Async reset in the 3rd ADD cycle: load, DELAY, ADD1, ADD2 edges then ADD3
        a16 = 16'h005A; b16 = 16'h003C; sub = 1'b0;
        en[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bsy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_out",   32'(res[0]), 32'h0);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        chk("abort_busy",  32'(bsy[0]), 32'd0);
        chk("abort_done",  32'(dn[0]),  32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run(0, 16'h0010, 16'h0020, 1'b1, 10, 1'b0);
        chk("post_rst_out", 32'(res[0]), 32'hF0);

        // 16-bit, two 8-bit digits, maximum pre-delay
        run(4, 16'h7FFF, 16'h0001, 1'b0, 18, 1'b0);
        chk("w16_out",  32'(res[4]), 32'h8000);
        chk("w16_cout", 32'(co[4]),  32'd0);
        chk("w16_ovf",  32'(ov[4]),  32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
